// File: rtl/tsp_io_pkg.sv
// Shared definitions for the TSP solver serial front end: ASCII constants and
// the UART receive state encoding.
package tsp_io_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/spec_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a pop frees the slot a same-cycle
// push may take, so a full FIFO accepts a push when it is also popped.
module spec_byte_fifo #(
    parameter int DEPTH_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [7:0]          push_data,
    input  logic                pop,
    output logic [7:0]          head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_BITS:0] level
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (DEPTH_BITS + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[DEPTH_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_BITS-1:0]] <= push_data;
    end

endmodule

// File: rtl/spec_uart_rx.sv
// 8N1 UART receiver feeding tsp: synchroniser, RX FSM, CR/LF normalisation,
// byte FIFO and a strobed output stage that never issues back-to-back bytes.
module spec_uart_rx
    import tsp_io_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     ready_to_read,
    output logic [7:0]               specdata,
    output logic                     has_specdata,
    output logic                     overflow,
    output logic                     frame_err,
    output logic [FIFO_DEPTH_BITS:0] fifo_level
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_MAX = BW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1, sync2;
    rx_state_t       state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            stop_wait;
    logic            byte_valid;
    logic [7:0]      rx_byte;
    logic            last_was_cr;

    logic            push;
    logic [7:0]      push_data;
    logic            pop;
    logic [7:0]      head;
    logic            full;
    logic            empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            stop_wait  <= 1'b0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    if (!sync2) state <= RX_START;
                end
                RX_START: begin
                    if (baud_cnt == HALF_MAX) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BAUD_MAX) begin
                        baud_cnt <= '0;
                        shift    <= {sync2, shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // After a bad stop bit, hold here until the line returns high.
                    if (stop_wait) begin
                        if (sync2) begin
                            stop_wait <= 1'b0;
                            state     <= RX_IDLE;
                        end
                    end else if (baud_cnt == BAUD_MAX) begin
                        baud_cnt <= '0;
                        if (sync2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            stop_wait <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // tsp ends lines on CR only: CRLF collapses to CR, a lone LF becomes CR.
    always_comb begin
        push      = 1'b0;
        push_data = rx_byte;
        if (byte_valid) begin
            if (rx_byte == ASCII_LF) begin
                push      = ~last_was_cr;
                push_data = ASCII_CR;
            end else begin
                push = 1'b1;
            end
        end
    end

    assign pop = ~empty & ready_to_read & ~has_specdata;

    spec_byte_fifo #(
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_was_cr  <= 1'b0;
            overflow     <= 1'b0;
            has_specdata <= 1'b0;
            specdata     <= '0;
        end else begin
            if (byte_valid) last_was_cr <= (rx_byte == ASCII_CR);
            if (push && full && !pop) overflow <= 1'b1;
            has_specdata <= pop;
            if (pop) specdata <= head;
        end
    end

endmodule

// File: tb/tb_spec_uart_rx.sv
// Directed and randomized bench for spec_uart_rx at CLKS_PER_BIT=4; expected
// bytes come from a queue-level model of the line-ending and FIFO rules.
module tb_spec_uart_rx;

    localparam int CPB = 4;
    localparam int FDB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx = 1'b1;
    logic           ready_to_read = 1'b0;
    logic [7:0]     specdata;
    logic           has_specdata;
    logic           overflow;
    logic           frame_err;
    logic [FDB:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic [7:0] pend[$];
    logic       model_cr = 1'b0;
    logic       model_ovf = 1'b0;
    logic       prev_has = 1'b0;
    logic       rdy_q = 1'b0;

    spec_uart_rx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_BITS (FDB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .ready_to_read (ready_to_read),
        .specdata      (specdata),
        .has_specdata  (has_specdata),
        .overflow      (overflow),
        .frame_err     (frame_err),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: captures bytes and checks spacing / ready qualification.
    always @(negedge clk) begin
        if (!rst && has_specdata) begin
            got.push_back(specdata);
            chk("strobe_from_ready", 32'(rdy_q), 32'd1);
            chk("strobe_gap", 32'(prev_has), 32'd0);
        end
        prev_has = has_specdata;
        rdy_q    = ready_to_read;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = stop_bit;
        cyc(CPB);
        rx = 1'b1;
        cyc(CPB);
    endtask

    // Reference: CR passes, LF after CR vanishes, other LF becomes CR.
    task automatic model_rx(input logic [7:0] b, input bit capped);
        logic [7:0] o;
        bit keep;
        keep = 1'b1;
        o = b;
        if (b == 8'h0A) begin
            if (model_cr) keep = 1'b0;
            o = 8'h0D;
        end
        model_cr = (b == 8'h0D);
        if (keep) begin
            if (capped && pend.size() >= 16) model_ovf = 1'b1;
            else pend.push_back(o);
        end
    endtask

    task automatic tx(input logic [7:0] b, input bit capped);
        send(b, 1'b1);
        model_rx(b, capped);
    endtask

    task automatic check_deliver(input string tag);
        int budget;
        budget = 200 + 8 * pend.size();
        while (got.size() < pend.size() && budget > 0) begin
            cyc(1);
            budget--;
        end
        cyc(20);
        chk({tag, "_count"}, 32'(got.size()), 32'(pend.size()));
        for (int i = 0; i < pend.size() && i < got.size(); i++)
            chk({tag, "_byte"}, 32'(got[i]), 32'(pend[i]));
        got.delete();
        pend.delete();
    endtask

    initial begin
        logic [7:0] r;
        cyc(3);
        chk("rst_has", 32'(has_specdata), 32'd0);
        chk("rst_data", 32'(specdata), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        cyc(4);

        ready_to_read = 1'b1;
        tx(8'h45, 0); tx(8'h4F, 0); tx(8'h46, 0); tx(8'h0D, 0);
        check_deliver("eof");
        chk("eof_ovf", 32'(overflow), 32'd0);
        chk("eof_ferr", 32'(frame_err), 32'd0);

        tx(8'h41, 0); tx(8'h0D, 0); tx(8'h0A, 0); tx(8'h42, 0); tx(8'h0A, 0);
        check_deliver("crlf");

        ready_to_read = 1'b0;
        for (int i = 0; i < 17; i++) tx(8'(8'h30 + i), 1);
        cyc(10);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'(model_ovf));
        chk("ovf_nostrobe", 32'(got.size()), 32'd0);
        ready_to_read = 1'b1;
        check_deliver("ovf");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_drained", 32'(fifo_level), 32'd0);

        send(8'h55, 1'b0);
        cyc(6);
        chk("ferr_flag", 32'(frame_err), 32'd1);
        chk("ferr_nostrobe", 32'(got.size()), 32'd0);
        tx(8'h31, 0);
        check_deliver("ferr_next");

        rx = 1'b0;
        cyc(1);
        rx = 1'b1;
        cyc(12);
        chk("glitch_level", 32'(fifo_level), 32'd0);
        chk("glitch_nostrobe", 32'(got.size()), 32'd0);

        rx = 1'b0;
        cyc(CPB * 3);
        rx = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_cr = 1'b0;
        cyc(1);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        got.delete();
        tx(8'h44, 0);
        check_deliver("after_rst");

        ready_to_read = 1'b0;
        tx(8'h61, 0); tx(8'h62, 0); tx(8'h63, 0); tx(8'h64, 0);
        cyc(6);
        chk("toggle_level", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 40; i++) begin
            ready_to_read = ~ready_to_read;
            cyc(1);
        end
        ready_to_read = 1'b1;
        check_deliver("toggle");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: r = 8'h0D;
                1: r = 8'h0A;
                default: r = 8'($urandom);
            endcase
            tx(r, 0);
            cyc($urandom_range(0, 5));
        end
        check_deliver("rand");
        chk("rand_ovf", 32'(overflow), 32'd0);
        chk("rand_ferr", 32'(frame_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
